// File: rtl/sdma_inst_sched.sv
// Multi-requester instruction scheduler: round-robin intake into a shared FIFO,
// one instruction in flight to sdma_top_ctrl, completion reported with requester ID.
`ifndef SDMA_INSTWIDTH
`define SDMA_INSTWIDTH 32
`endif

module sdma_inst_sched #(
  parameter int NUM_REQ = 2,
  parameter int INST_W  = `SDMA_INSTWIDTH,
  parameter int DEPTH   = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_isq_en,
  input  logic [NUM_REQ-1:0]        i_isq_req_vld,
  input  logic [NUM_REQ*INST_W-1:0] i_isq_req_inst,
  output logic [NUM_REQ-1:0]        o_isq_req_rdy,
  output logic                      o_isq_stc_en,
  output logic                      o_isq_stc_inst_vld,
  output logic [INST_W-1:0]         o_isq_stc_inst,
  input  logic                      i_isq_stc_ready,
  output logic                      o_isq_done_vld,
  output logic [ID_W-1:0]           o_isq_done_id,
  output logic [$clog2(DEPTH):0]    o_isq_fifo_cnt,
  output logic                      o_isq_busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ID_W-1:0]   mem_id   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % NUM_REQ;
    return ID_W'(sum);
  endfunction

  assign fifo_full      = (cnt == CNT_W'(DEPTH));
  assign fifo_empty     = (cnt == '0);
  assign pop            = (state == WAIT_DONE) && i_isq_stc_ready;
  assign o_isq_fifo_cnt = cnt;

  // Descending scan so the requester closest to rr_ptr is the last (winning) match.
  always_comb begin
    o_isq_req_rdy = '0;
    win_id        = '0;
    push          = 1'b0;
    if (!fifo_full) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (i_isq_req_vld[rr_idx(rr_ptr, k)]) begin
          win_id = rr_idx(rr_ptr, k);
          push   = 1'b1;
        end
      end
    end
    if (push) o_isq_req_rdy[win_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= i_isq_req_inst[int'(win_id)*INST_W +: INST_W];
      mem_id[wr_ptr]   <= win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= rr_idx(win_id, 1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // inst_vld drops only after top ctrl has shown busy (ready low) for one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      o_isq_stc_en       <= 1'b0;
      o_isq_stc_inst_vld <= 1'b0;
      o_isq_stc_inst     <= '0;
      o_isq_done_vld     <= 1'b0;
      o_isq_done_id      <= '0;
      o_isq_busy         <= 1'b0;
    end else begin
      o_isq_done_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty && i_isq_en && i_isq_stc_ready) begin
            state              <= ISSUE;
            o_isq_stc_en       <= 1'b1;
            o_isq_stc_inst_vld <= 1'b1;
            o_isq_stc_inst     <= mem_inst[rd_ptr];
            o_isq_busy         <= 1'b1;
          end
        end
        ISSUE: begin
          if (!i_isq_stc_ready) begin
            state              <= WAIT_DONE;
            o_isq_stc_inst_vld <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (i_isq_stc_ready) begin
            state          <= IDLE;
            o_isq_stc_en   <= 1'b0;
            o_isq_busy     <= 1'b0;
            o_isq_done_vld <= 1'b1;
            o_isq_done_id  <= mem_id[rd_ptr];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pop_on_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule

// File: tb/tb_sdma_inst_sched.sv
// Randomised scoreboard bench for sdma_inst_sched with a behavioural top-ctrl responder.
module tb_sdma_inst_sched;
  localparam int NUM_REQ = 2;
  localparam int INST_W  = 32;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      en;
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*INST_W-1:0] req_inst;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      stc_en;
  logic                      stc_inst_vld;
  logic [INST_W-1:0]         stc_inst;
  logic                      stc_ready;
  logic                      done_vld;
  logic [ID_W-1:0]           done_id;
  logic [$clog2(DEPTH):0]    fifo_cnt;
  logic                      busy;

  typedef struct {
    int                id;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             exp_q[$];
  int                 total = 0;
  int                 bad   = 0;
  int                 m_cnt;
  int                 m_rr;
  bit                 m_flight;
  bit                 m_acc;
  bit                 m_done;
  bit                 pop_now;
  int                 win;
  logic [NUM_REQ-1:0] exp_grant;
  int                 resp_busy;
  bit                 prev_vld;
  logic [INST_W-1:0]  issued_inst;

  sdma_inst_sched #(
    .NUM_REQ(NUM_REQ), .INST_W(INST_W), .DEPTH(DEPTH), .ID_W(ID_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_isq_en           (en),
    .i_isq_req_vld      (req_vld),
    .i_isq_req_inst     (req_inst),
    .o_isq_req_rdy      (req_rdy),
    .o_isq_stc_en       (stc_en),
    .o_isq_stc_inst_vld (stc_inst_vld),
    .o_isq_stc_inst     (stc_inst),
    .i_isq_stc_ready    (stc_ready),
    .o_isq_done_vld     (done_vld),
    .o_isq_done_id      (done_id),
    .o_isq_fifo_cnt     (fifo_cnt),
    .o_isq_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester at or after the pointer, nothing when full.
  function automatic int pick_requester(input logic [NUM_REQ-1:0] vld, input int rr, input int cnt);
    if (cnt >= DEPTH) return -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (vld[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic applyStimulus(input int vld_pct, input int en_pct, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        req_vld[r] = ($urandom_range(0, 99) < vld_pct);
        req_inst[r*INST_W +: INST_W] = $urandom;
      end
      en = ($urandom_range(0, 99) < en_pct);
    end
  endtask

  // Behavioural top ctrl: accepts after a random delay, stays busy, occasionally stalls while idle.
  initial begin
    stc_ready = 1'b1;
    resp_busy = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        stc_ready = 1'b1;
        resp_busy = 0;
      end else if (resp_busy > 0) begin
        resp_busy--;
        if (resp_busy == 0) stc_ready = 1'b1;
      end else if (stc_inst_vld && stc_ready) begin
        if ($urandom_range(0, 2) != 0) begin
          stc_ready = 1'b0;
          resp_busy = $urandom_range(1, 4);
        end
      end else if (!stc_inst_vld && stc_ready && $urandom_range(0, 7) == 0) begin
        stc_ready = 1'b0;
        resp_busy = $urandom_range(1, 3);
      end
    end
  end

  // Reference model: checks the current cycle, then advances over the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_rr = 0; m_flight = 0; m_acc = 0; m_done = 0;
      exp_q.delete();
      checkOutput("rst_fifo_cnt", fifo_cnt, 0);
      checkOutput("rst_inst_vld", stc_inst_vld, 0);
      checkOutput("rst_stc_en", stc_en, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done_vld", done_vld, 0);
      checkOutput("rst_done_id", done_id, 0);
      checkOutput("rst_inst", stc_inst, 0);
    end else begin
      win       = pick_requester(req_vld, m_rr, m_cnt);
      exp_grant = '0;
      if (win >= 0) exp_grant[win] = 1'b1;
      checkOutput("req_rdy", req_rdy, exp_grant);
      checkOutput("fifo_cnt", fifo_cnt, m_cnt);
      checkOutput("inst_vld", stc_inst_vld, m_flight && !m_acc);
      checkOutput("stc_en", stc_en, m_flight);
      checkOutput("busy", busy, m_flight);
      checkOutput("done_vld", done_vld, m_done);
      m_done  = 0;
      pop_now = 0;
      if (!m_flight) begin
        if (m_cnt > 0 && en && stc_ready) begin
          m_flight = 1;
          m_acc    = 0;
        end
      end else if (!m_acc) begin
        if (!stc_ready) m_acc = 1;
      end else if (stc_ready) begin
        m_flight = 0;
        m_done   = 1;
        pop_now  = 1;
      end
      if (win >= 0) begin
        exp_q.push_back('{win, req_inst[win*INST_W +: INST_W]});
        m_rr = (win + 1) % NUM_REQ;
      end
      m_cnt = m_cnt + ((win >= 0) ? 1 : 0) - (pop_now ? 1 : 0);
    end
  end

  // Monitor: compares issued instructions and completions against the scoreboard queue.
  initial begin
    prev_vld    = 1'b0;
    issued_inst = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        prev_vld = 1'b0;
      end else begin
        if (stc_inst_vld && !prev_vld) begin
          checkOutput("issue_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            checkOutput("issue_inst", stc_inst, exp_q[0].inst);
            issued_inst = exp_q[0].inst;
          end
        end
        if (done_vld) begin
          checkOutput("done_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            checkOutput("done_id", done_id, exp_q[0].id);
            checkOutput("inst_held", stc_inst, issued_inst);
            void'(exp_q.pop_front());
          end
        end
        prev_vld = stc_inst_vld;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    en       = 1'b0;
    req_vld  = '0;
    req_inst = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill with issue disabled: accept order 0,1,0,1, then no grant while full.
    applyStimulus(100, 0, 8);
    // Continuous demand with issue enabled: full FIFO popping while requests wait.
    applyStimulus(100, 100, 60);
    applyStimulus(50, 80, 300);
    applyStimulus(30, 30, 200);

    // Reset while an instruction is in WAIT_DONE with the FIFO loaded.
    applyStimulus(100, 0, 6);
    @(posedge clk); #1;
    req_vld = '0;
    en      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !stc_inst_vld) && n < 60);
    checkOutput("reach_wait_done", busy && !stc_inst_vld, 1);
    checkOutput("queued_at_reset", fifo_cnt >= 3, 1);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 100, 5);

    applyStimulus(60, 70, 250);

    // Drain everything and confirm every queued instruction completed.
    applyStimulus(0, 100, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fifo_cnt == 0 && !busy) && n < 200);
    checkOutput("drained", fifo_cnt == 0 && !busy, 1);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
